ca_digit_serializer_hd: RTL and testbench
=========================================

Name: ca_digit_serializer_hd

Overview:
- Return-path counterpart of the per-digit CA register write path.
- Accepts 4-digit unrolled signed-digit groups for x and y as plus/minus bit vectors from the compute datapath.
- Buffers the groups in a small FIFO and replays them one digit per cycle, most significant digit first, as 2-bit {plus,minus} x/y values.
- Maintains a digit counter with the same layout as master_cnt (group address in upper bits, digit select in [1:0]) so downstream writers can consume it directly.

Parameters:
- Num_bits, 4: digits per group; fixed at 4 (digit select is 2 bits).
- RAM_ADDR_WIDTH, 7: group address width of digit_cnt; digit_cnt is RAM_ADDR_WIDTH+2 bits.
- FIFO_AW, 2: log2 of FIFO depth in groups; depth = 4 by default.

Ports:
- clk  input  1  rising-edge clock.
- asyn_reset  input  1  asynchronous, active-high reset.
- enable_all  input  1  global enable; when 0 the block freezes.
- in_valid  input  1  group offered.
- in_ready  output  1  group accepted when in_valid && in_ready at a clock edge.
- x_plus, x_minus, y_plus, y_minus  input  4 each  group digits; index 3 is the MSD.
- out_ready  input  1  consumer accepts the current digit.
- out_valid  output  1  x_value/y_value are valid.
- x_value  output  2  {x_plus[k], x_minus[k]} for the current digit k.
- y_value  output  2  {y_plus[k], y_minus[k]} for the current digit k.
- out_last  output  1  the current digit is k=0, the last of its group.
- digit_cnt  output  RAM_ADDR_WIDTH+2  emitted-digit counter.
- illegal_digit  output  1  sticky flag: an accepted group contained a 11 digit.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0 (each FIFO_AW+1 bits), sel=0, digit_cnt=0, illegal_digit=0. FIFO contents are don't-care.
- While reset is held: out_valid=0, x_value=y_value=00, out_last=0, in_ready=enable_all.
- FIFO storage: one 16-bit entry per group, {x_plus, x_minus, y_plus, y_minus}, written at wr_ptr.
- Derived flags:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs of the pointers differ and the lower bits are equal.
- in_ready = enable_all && !full (combinational). A full FIFO does not accept, even if the head group completes in the same cycle.
- push = in_valid && in_ready. On push: store the group and increment wr_ptr (wraps modulo 2^(FIFO_AW+1)).
- out_valid = enable_all && !empty.
- Output mapping: combinational read of the head entry at digit k = 3 - sel.
  - sel 00 → index 3, 01 → index 2, 10 → index 1, 11 → index 0.
  - out_last = out_valid && (sel == 2'b11).
  - When !out_valid: x_value = y_value = 00.
- pop = out_valid && out_ready. On pop:
  - sel increments (wraps 3→0).
  - digit_cnt increments (wraps modulo 2^(RAM_ADDR_WIDTH+2)).
  - If sel == 3, rd_ptr increments.
- Latency: a group pushed at edge N presents its MSD starting in the cycle after edge N, if the FIFO was empty.
- Steady state: 4 digits per group with no bubbles between back-to-back groups.
- Simultaneous push and final-digit pop: both take effect; occupancy is unchanged.
- enable_all = 0:
  - No push, no pop.
  - in_ready = 0, out_valid = 0.
  - All state, including sel and digit_cnt, is held.
  - Resumes exactly where it stopped.
- out_ready low while out_valid: hold the same digit; sel and digit_cnt are held.
- Digit encoding:
  - 10 = +1, 01 = -1, 00 = 0.
  - 11 is passed through unchanged, and sets illegal_digit on the push edge if any of the 8 digit positions (x or y) has plus & minus both 1.
  - illegal_digit is cleared only by reset.
- Reset mid-group: the partial group is discarded; the next emitted digit after reset is the MSD of the next group pushed.
- digit_cnt[1:0] always equals sel.

Test Plan:
- Reset, enable_all=1, push one group x_plus=4'b1010, x_minus=4'b0100, y_plus=4'b0001, y_minus=4'b1000, out_ready=1 → next 4 cycles:
  - x_value = 10, 01, 10, 00; y_value = 01, 00, 00, 10.
  - out_last only on the 4th cycle; digit_cnt 0→4; then out_valid=0.
- Push 5 groups back-to-back with out_ready=0 → in_ready drops after the 4th accepted group; the 5th is held off. Raise out_ready → the 5th is accepted in the cycle after the first group's 4th digit pops; 20 digits stream with no gaps.
- out_ready toggled 1,0,0,1 mid-group → the digit is held across the stalled cycles; sel and digit_cnt advance only on pop cycles.
- enable_all dropped for 3 cycles mid-group (sel=2) → out_valid=0 and in_ready=0 for those cycles; after re-enable the stream resumes at sel=2 with the same group.
- Push a group with x_plus[1]=x_minus[1]=1 → illegal_digit=1 from the next cycle; the digit is emitted as 11; the flag persists after the group drains; asyn_reset clears it.
- Run 2^(RAM_ADDR_WIDTH+2)+4 = 516 digits → digit_cnt wraps 511→0. Assert asyn_reset with sel=1 → out_valid=0 and digit_cnt=0 immediately (asynchronously), and the FIFO is empty.

Source files
------------

// File: rtl/ca_digit_serializer_hd_if.sv
// ---------------------------------------------------------------------------
// ca_digit_serializer_hd_if
// Bundles the group input handshake, the digit output handshake and the
// status outputs of ca_digit_serializer_hd.
//   master : the producer/consumer side (drives groups, enable_all, out_ready)
//   slave  : the serializer itself
// Signals:
//   enable_all                         global enable
//   in_valid / in_ready                group handshake
//   x_plus, x_minus, y_plus, y_minus   group digits, index 3 is the MSD
//   out_valid / out_ready              digit handshake
//   x_value, y_value                   {plus,minus} of the current digit
//   out_last                           current digit is the last of its group
//   digit_cnt                          emitted-digit counter {group, digit}
//   illegal_digit                      sticky "11 digit accepted" flag
// ---------------------------------------------------------------------------
interface ca_digit_serializer_hd_if #(
  parameter int RAM_ADDR_WIDTH = 7
);
  logic                      enable_all;
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                x_plus;
  logic [3:0]                x_minus;
  logic [3:0]                y_plus;
  logic [3:0]                y_minus;
  logic                      out_ready;
  logic                      out_valid;
  logic [1:0]                x_value;
  logic [1:0]                y_value;
  logic                      out_last;
  logic [RAM_ADDR_WIDTH+1:0] digit_cnt;
  logic                      illegal_digit;

  modport master (
    output enable_all, in_valid, x_plus, x_minus, y_plus, y_minus, out_ready,
    input  in_ready, out_valid, x_value, y_value, out_last, digit_cnt, illegal_digit
  );

  modport slave (
    input  enable_all, in_valid, x_plus, x_minus, y_plus, y_minus, out_ready,
    output in_ready, out_valid, x_value, y_value, out_last, digit_cnt, illegal_digit
  );
endinterface

// File: rtl/ca_digit_serializer_hd.sv
// ---------------------------------------------------------------------------
// ca_digit_serializer_hd
// Buffers 4-digit signed-digit groups (x and y, plus/minus vectors) in a small
// FIFO and replays them one digit per cycle, MSD first, as 2-bit {plus,minus}
// values. A digit counter laid out like master_cnt ({group address, digit
// select}) follows the emitted digits.
// Ports:
//   clk         rising-edge clock
//   asyn_reset  asynchronous active-high reset
//   bus         ca_digit_serializer_hd_if.slave (handshakes, digits, status)
// ---------------------------------------------------------------------------
module ca_digit_serializer_hd #(
  parameter int Num_bits       = 4,
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int FIFO_AW        = 2
) (
  input  logic                    clk,
  input  logic                    asyn_reset,
  ca_digit_serializer_hd_if.slave bus
);

  localparam int                SEL_W   = $clog2(Num_bits);
  localparam int                CNT_W   = RAM_ADDR_WIDTH + 2;
  localparam int                DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  PTR_ONE = (FIFO_AW + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [SEL_W-1:0]  SEL_MAX = SEL_W'(Num_bits - 1);

  // A digit position with both plus and minus set is not a valid encoding.
  function automatic logic has_illegal_digit(input logic [15:0] grp);
    return |((grp[15:12] & grp[11:8]) | (grp[7:4] & grp[3:0]));
  endfunction

  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic               illegal_q, illegal_d;
  logic [15:0]        mem_q [DEPTH];

  logic               empty_s;
  logic               full_s;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               pop_s;
  logic [SEL_W-1:0]   sel_s;
  logic [SEL_W-1:0]   k_s;
  logic [15:0]        group_s;
  logic [15:0]        head_s;
  logic [3:0]         xp_s, xm_s, yp_s, ym_s;

  // The digit select is the low part of the digit counter, so the two can
  // never disagree.
  assign sel_s   = digit_cnt_q[SEL_W-1:0];
  assign k_s     = SEL_MAX - sel_s;
  assign group_s = {bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus};
  assign head_s  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign xp_s    = head_s[15:12];
  assign xm_s    = head_s[11:8];
  assign yp_s    = head_s[7:4];
  assign ym_s    = head_s[3:0];

  // FIFO flags and handshakes; full is judged on the current pointers only,
  // so a completing head group does not free a slot in the same cycle.
  always_comb begin
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    in_ready_s  = bus.enable_all && !full_s;
    out_valid_s = bus.enable_all && !empty_s;
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Next-state for pointers, digit counter and the sticky illegal flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    digit_cnt_d = digit_cnt_q;
    illegal_d   = illegal_q;
    if (push_s) begin
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      illegal_d = illegal_q | has_illegal_digit(group_s);
    end else begin
      wr_ptr_d  = wr_ptr_q;
    end
    if (pop_s) begin
      digit_cnt_d = digit_cnt_q + CNT_ONE;
      if (sel_s == SEL_MAX) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end else begin
      digit_cnt_d = digit_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      digit_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      digit_cnt_q <= digit_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  // Group storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= group_s;
    end
  end

  // Output mapping: head entry at digit k = 3 - sel, zeros when not valid.
  always_comb begin
    bus.in_ready      = in_ready_s;
    bus.out_valid     = out_valid_s;
    bus.digit_cnt     = digit_cnt_q;
    bus.illegal_digit = illegal_q;
    bus.x_value       = 2'b00;
    bus.y_value       = 2'b00;
    bus.out_last      = 1'b0;
    if (out_valid_s) begin
      bus.x_value  = {xp_s[k_s], xm_s[k_s]};
      bus.y_value  = {yp_s[k_s], ym_s[k_s]};
      bus.out_last = (sel_s == SEL_MAX);
    end else begin
      bus.x_value  = 2'b00;
      bus.y_value  = 2'b00;
      bus.out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_ca_digit_serializer_hd.sv
module tb_ca_digit_serializer_hd;
  localparam int RAW     = 7;
  localparam int CNT_MOD = 1 << (RAW + 2);
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic asyn_reset;
  always #5 clk = ~clk;

  ca_digit_serializer_hd_if #(.RAM_ADDR_WIDTH(RAW)) bus ();

  ca_digit_serializer_hd #(
    .Num_bits(4), .RAM_ADDR_WIDTH(RAW), .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .asyn_reset(asyn_reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored groups, digit index inside the head
  // group, emitted-digit count and the sticky illegal flag.
  logic [15:0] mq[$];
  int          m_idx;
  int          m_cnt;
  bit          m_ill;

  logic [15:0] pend[$];
  bit          en;
  bit          ordy;
  bit          rand_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit grp_illegal(input logic [15:0] g);
    bit r = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[12+i] && g[8+i]) r = 1;
      if (g[4+i] && g[i]) r = 1;
    end
    return r;
  endfunction

  // Random group: each of the 8 digits is 0, +1 or -1, plus an optional 11.
  function automatic logic [15:0] gen_group(input bit allow_bad);
    logic [3:0] xp = '0, xm = '0, yp = '0, ym = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0: ;
        1: xp[i] = 1'b1;
        default: xm[i] = 1'b1;
      endcase
      case ($urandom_range(0, 2))
        0: ;
        1: yp[i] = 1'b1;
        default: ym[i] = 1'b1;
      endcase
    end
    if (allow_bad) begin
      int p = $urandom_range(0, 7);
      if (p < 4) begin xp[p] = 1'b1; xm[p] = 1'b1; end
      else begin yp[p-4] = 1'b1; ym[p-4] = 1'b1; end
    end
    return {xp, xm, yp, ym};
  endfunction

  task automatic drive();
    bus.enable_all = en;
    bus.out_ready  = ordy;
    if (pend.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      bus.in_valid = 1'b1;
      {bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus} = pend[0];
    end else begin
      bus.in_valid = 1'b0;
      {bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus} = 16'($urandom);
    end
  endtask

  // One clock: drive, check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    bit exp_ir, exp_ov, exp_last, push, pop;
    logic [1:0] ex, ey;
    logic [15:0] g;
    int k;
    drive();
    @(negedge clk);
    exp_ir   = en && (mq.size() < DEPTH);
    exp_ov   = en && (mq.size() != 0);
    ex       = 2'b00;
    ey       = 2'b00;
    exp_last = 1'b0;
    if (exp_ov) begin
      g        = mq[0];
      k        = 3 - m_idx;
      ex       = {g[12+k], g[8+k]};
      ey       = {g[4+k], g[k]};
      exp_last = (m_idx == 3);
    end
    chk("in_ready",      32'(bus.in_ready),      32'(exp_ir));
    chk("out_valid",     32'(bus.out_valid),     32'(exp_ov));
    chk("x_value",       32'(bus.x_value),       32'(ex));
    chk("y_value",       32'(bus.y_value),       32'(ey));
    chk("out_last",      32'(bus.out_last),      32'(exp_last));
    chk("digit_cnt",     32'(bus.digit_cnt),     32'(m_cnt));
    chk("illegal_digit", 32'(bus.illegal_digit), 32'(m_ill));
    @(posedge clk);
    push = bus.in_valid && exp_ir;
    pop  = exp_ov && ordy;
    if (pop) begin
      m_idx++;
      m_cnt = (m_cnt + 1) % CNT_MOD;
      if (m_idx == 4) begin
        void'(mq.pop_front());
        m_idx = 0;
      end
    end
    if (push) begin
      mq.push_back(pend[0]);
      if (grp_illegal(pend[0])) m_ill = 1'b1;
      void'(pend.pop_front());
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asynchronous reset applied between edges; its effect is checked at once.
  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.enable_all = en;
    asyn_reset     = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid),     32'd0);
    chk("rst_digit_cnt", 32'(bus.digit_cnt),     32'd0);
    chk("rst_x_value",   32'(bus.x_value),       32'd0);
    chk("rst_y_value",   32'(bus.y_value),       32'd0);
    chk("rst_out_last",  32'(bus.out_last),      32'd0);
    chk("rst_illegal",   32'(bus.illegal_digit), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),      32'(en));
    mq.delete();
    m_idx = 0;
    m_cnt = 0;
    m_ill = 1'b0;
    @(posedge clk);
    #1;
    asyn_reset = 1'b0;
  endtask

  initial begin
    asyn_reset    = 1'b1;
    en            = 1'b1;
    ordy          = 1'b0;
    rand_valid    = 1'b0;
    bus.enable_all = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus} = 16'h0000;
    m_idx = 0;
    m_cnt = 0;
    m_ill = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run(2);

    // Single known group, drained with out_ready high.
    pend.push_back({4'b1010, 4'b0100, 4'b0001, 4'b1000});
    ordy = 1'b1;
    run(7);
    chk("first_group_cnt", 32'(bus.digit_cnt), 32'd4);

    // Five groups with the consumer stalled, then released.
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) pend.push_back(gen_group(1'b0));
    run(6);
    chk("fifth_held", 32'(pend.size()), 32'd1);
    ordy = 1'b1;
    run(24);

    // Consumer stalls mid-group.
    pend.push_back(gen_group(1'b0));
    run(1);
    ordy = 1'b1; run(1);
    ordy = 1'b0; run(2);
    ordy = 1'b1; run(4);

    // enable_all dropped with sel = 2.
    pend.push_back(gen_group(1'b0));
    run(3);
    en = 1'b0; run(3);
    en = 1'b1; run(4);

    // Group with an 11 digit at x index 1.
    pend.push_back({4'b0010, 4'b0010, 4'b0000, 4'b0000});
    run(7);
    chk("illegal_sticky", 32'(bus.illegal_digit), 32'd1);
    do_reset();
    run(1);

    // 516 digits: digit_cnt wraps 511 -> 0, then reset with sel = 1.
    for (int i = 0; i < 129; i++) pend.push_back(gen_group(1'b0));
    run(129 * 4 + 6);
    pend.push_back(gen_group(1'b0));
    run(2);
    chk("sel_before_reset", 32'(bus.digit_cnt[1:0]), 32'd1);
    do_reset();
    run(3);

    // Randomized traffic.
    rand_valid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (pend.size() < 2) pend.push_back(gen_group($urandom_range(0, 19) == 0));
      en   = ($urandom_range(0, 9) != 0);
      ordy = $urandom_range(0, 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
